// File: rtl/move_sched_pkg.sv
// Shared definitions for the move scheduler: direction codes, FSM state
// encoding and the button priority helper.
package game_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  // Lowest set request bit wins; the others are dropped.
  function automatic logic [1:0] lowest_dir(input logic [3:0] req);
    logic [1:0] d;
    d = DIR_UP;
    if (req[0])      d = DIR_UP;
    else if (req[1]) d = DIR_RIGHT;
    else if (req[2]) d = DIR_DOWN;
    else if (req[3]) d = DIR_LEFT;
    return d;
  endfunction

endpackage

// File: rtl/move_sched_if.sv
// Scheduler <-> board engine handshake: init/start pulses, held move
// direction, and the engine's done/stuck result.
interface move_sched_if;
  logic       init;
  logic       start;
  logic [1:0] dir;
  logic       done;
  logic       stuck;

  modport master (output init, output start, output dir, input done, input stuck);
  modport slave  (input init, input start, input dir, output done, output stuck);
endinterface

// File: rtl/move_sched_req_arb.sv
// Move request arbiter: pending slot > buttons > autoplay, evaluated only
// while the scheduler is idle. Optional 1-entry pending slot when
// MOVE_QUEUE_EN is defined.
module move_req_arb
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_req_i,
  input  logic       auto_en_i,
  input  logic       auto_valid_i,
  input  logic [1:0] auto_dir_i,
  input  logic       busy_i,
  input  logic       idle_i,
  input  logic       new_game_i,
  input  logic       flush_i,
  output logic       sel_valid_o,
  output logic [1:0] sel_dir_o,
  output logic       auto_ready_o
);

  logic       pend_v;
  logic [1:0] pend_dir;
  logic       btn_any;

  assign btn_any = |btn_req_i;

`ifdef MOVE_QUEUE_EN
  logic       pend_v_q, pend_v_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       take;

  // The slot can only be consumed in IDLE, and capture only happens while
  // busy, so take and capture never coincide.
  assign take = idle_i & sel_valid_o;

  // Pending slot next-state: flush > take > first capture while busy
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_dir_d = pend_dir_q;
    if (flush_i) begin
      pend_v_d = 1'b0;
    end else if (take) begin
      pend_v_d = 1'b0;
    end else if (busy_i && !pend_v_q && btn_any) begin
      pend_v_d   = 1'b1;
      pend_dir_d = lowest_dir(btn_req_i);
    end
  end

  // Pending slot register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q   <= 1'b0;
      pend_dir_q <= DIR_UP;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign pend_v   = pend_v_q;
  assign pend_dir = pend_dir_q;
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, busy_i, flush_i};
  assign pend_v    = 1'b0;
  assign pend_dir  = DIR_UP;
`endif

  assign auto_ready_o = idle_i & auto_en_i & ~pend_v & ~btn_any & ~new_game_i;
  assign sel_valid_o  = idle_i & ~new_game_i &
                        (pend_v | btn_any | (auto_valid_i & auto_ready_o));
  assign sel_dir_o    = pend_v  ? pend_dir :
                        btn_any ? lowest_dir(btn_req_i) : auto_dir_i;

endmodule

// File: rtl/move_sched.sv
// 2048 move scheduler: arbitrates move requests, issues one move at a time
// to the board engine, runs the per-move watchdog, counts moves and latches
// game-over. Optional pending-move slot enabled by MOVE_QUEUE_EN.
module move_sched
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game_i,
  input  logic [3:0]       btn_req_i,
  input  logic             auto_en_i,
  input  logic             auto_valid_i,
  input  logic [1:0]       auto_dir_i,
  output logic             auto_ready_o,
  move_sched_if.master     eng,
  output logic             busy_o,
  output logic             game_over_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] move_count_o
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             over_q, over_d;
  logic             tmo_q, tmo_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             idle;
  logic             sel_valid;
  logic [1:0]       sel_dir;
  logic             enter_init;
  logic             flush;

  assign idle = (state_q == S_IDLE);

  move_req_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .btn_req_i    (btn_req_i),
    .auto_en_i    (auto_en_i),
    .auto_valid_i (auto_valid_i),
    .auto_dir_i   (auto_dir_i),
    .busy_i       (busy_o),
    .idle_i       (idle),
    .new_game_i   (new_game_i),
    .flush_i      (flush),
    .sel_valid_o  (sel_valid),
    .sel_dir_o    (sel_dir),
    .auto_ready_o (auto_ready_o)
  );

  // Next state, watchdog, counters and flags
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    tmo_d   = tmo_q;
    wd_d    = wd_q;
    init_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (new_game_i) begin
          state_d = S_INIT;
        end else if (sel_valid) begin
          state_d = S_ISSUE;
          dir_d   = sel_dir;
        end
      end
      S_INIT: begin
        if (eng.done) state_d = S_IDLE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = new_game_i ? S_INIT : S_WAIT;
      end
      S_WAIT: begin
        if (new_game_i) begin
          state_d = S_INIT;
        end else if (eng.done) begin
          if (eng.stuck) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            state_d = S_IDLE;
          end
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_OVER: begin
        if (new_game_i) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
    // Board state is wiped on the transition into INIT so eng_init and the
    // cleared status appear together on the first INIT cycle.
    enter_init = (state_d == S_INIT) && (state_q != S_INIT);
    if (enter_init) begin
      init_d = 1'b1;
      cnt_d  = '0;
      over_d = 1'b0;
    end
    flush = enter_init || ((state_d == S_OVER) && (state_q != S_OVER));
  end

  // State and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_UP;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
    end
  end

  assign eng.init     = init_q;
  assign eng.start    = (state_q == S_ISSUE);
  assign eng.dir      = dir_q;
  assign busy_o       = (state_q == S_INIT) || (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign game_over_o  = over_q;
  assign timeout_o    = tmo_q;
  assign move_count_o = cnt_q;

endmodule

// File: tb/tb_move_sched.sv
// Directed bench for move_sched: a per-cycle vector table for the main
// sequencing, plus hand-written sequences for watchdog and pending slot.
module tb_move_sched;
  import game_pkg::*;

  logic       clk;
  logic       rst;
  logic       new_game;
  logic [3:0] btn_req;
  logic       auto_en, auto_valid;
  logic [1:0] auto_dir;
  logic       auto_ready;
  logic       busy, game_over, timeout;
  logic [1:0] move_count;

  int checks = 0;
  int errors = 0;

  move_sched_if eng_if ();

  move_sched #(.TIMEOUT_CYC(8), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game_i   (new_game),
    .btn_req_i    (btn_req),
    .auto_en_i    (auto_en),
    .auto_valid_i (auto_valid),
    .auto_dir_i   (auto_dir),
    .auto_ready_o (auto_ready),
    .eng          (eng_if),
    .busy_o       (busy),
    .game_over_o  (game_over),
    .timeout_o    (timeout),
    .move_count_o (move_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ng;
    logic [3:0] btn;
    logic       ae, av;
    logic [1:0] ad;
    logic       done, stuck;
    logic       busy, init, start;
    logic [1:0] dir;
    logic       ready;
    logic [1:0] cnt;
    logic       over;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ng, logic [3:0] btn, logic ae, logic av, logic [1:0] ad,
                              logic done, logic stuck, logic b, logic i, logic s,
                              logic [1:0] d, logic r, logic [1:0] c, logic o);
    vec_t v;
    v.ng = ng; v.btn = btn; v.ae = ae; v.av = av; v.ad = ad; v.done = done; v.stuck = stuck;
    v.busy = b; v.init = i; v.start = s; v.dir = d; v.ready = r; v.cnt = c; v.over = o;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ng, input logic [3:0] btn, input logic ae, input logic av,
                       input logic [1:0] ad, input logic done, input logic stuck);
    new_game = ng; btn_req = btn; auto_en = ae; auto_valid = av; auto_dir = ad;
    eng_if.done = done; eng_if.stuck = stuck;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_init", eng_if.init, 0);
    chk("rst_start", eng_if.start, 0);
    chk("rst_dir", eng_if.dir, 0);
    chk("rst_over", game_over, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_cnt", move_count, 0);
    chk("rst_ready", auto_ready, 0);
    cyc();
    rst = 1'b0;

    //        ng btn     ae av ad done st | busy init start dir ready cnt over
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // new game
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0)); // INIT entry
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0)); // init done
    tbl.push_back(mk(0, 4'b0110, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0)); // two buttons
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0)); // ISSUE right
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 0, 1, 0, 0, 0)); // move done
    tbl.push_back(mk(0, 4'b1000, 1, 1, 3, 0, 0,  0, 0, 0, 1, 0, 1, 0)); // btn beats auto
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0,  1, 0, 1, 3, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0, 0,  0, 0, 0, 3, 1, 2, 0)); // ready, no valid
    tbl.push_back(mk(0, 4'b0000, 1, 1, 2, 0, 0,  0, 0, 0, 3, 1, 2, 0)); // auto transfer
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 1, 2, 0, 2, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 1,  1, 0, 0, 2, 0, 2, 0)); // stuck
    tbl.push_back(mk(0, 4'b0001, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 2, 1)); // OVER ignores btn
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 0, 0,  0, 0, 0, 2, 0, 2, 1)); // and auto
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 2, 1)); // new game
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 1, 0, 2, 0, 0, 0)); // flags cleared
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1001, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0)); // ng beats btn
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0101, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0)); // ISSUE up
    tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0)); // abort in WAIT
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0)); // done in IDLE
    tbl.push_back(mk(0, 4'b1000, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 1, 3, 0, 0, 0)); // done in ISSUE
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 1, 0,  1, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 1, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].ng, tbl[i].btn, tbl[i].ae, tbl[i].av, tbl[i].ad, tbl[i].done, tbl[i].stuck);
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_init", i), eng_if.init, tbl[i].init);
      chk($sformatf("v%0d_start", i), eng_if.start, tbl[i].start);
      chk($sformatf("v%0d_dir", i), eng_if.dir, tbl[i].dir);
      chk($sformatf("v%0d_ready", i), auto_ready, tbl[i].ready);
      chk($sformatf("v%0d_cnt", i), move_count, tbl[i].cnt);
      chk($sformatf("v%0d_over", i), game_over, tbl[i].over);
      chk($sformatf("v%0d_tmo", i), timeout, 0);
      cyc();
    end

    // Watchdog expiry: timeout on the 8th WAIT cycle, move not counted
    idle_in();
    btn_req = 4'b0001;
    cyc();
    idle_in();
    @(negedge clk);
    chk("wd_start", eng_if.start, 1);
    cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("wd_wait%0d_busy", k), busy, 1);
      chk($sformatf("wd_wait%0d_tmo", k), timeout, 0);
      cyc();
    end
    @(negedge clk);
    chk("wd_idle", busy, 0);
    chk("wd_tmo", timeout, 1);
    chk("wd_cnt", move_count, 1);
    cyc();

    // done on the last watchdog cycle wins: move counted
    btn_req = 4'b0010;
    cyc();
    idle_in();
    cyc();
    for (int k = 1; k <= 7; k++) cyc();
    eng_if.done = 1'b1;
    @(negedge clk);
    chk("race_busy8", busy, 1);
    cyc();
    idle_in();
    @(negedge clk);
    chk("race_idle", busy, 0);
    chk("race_cnt", move_count, 2);
    chk("race_over", game_over, 0);
    cyc();

    // Button during WAIT: queued in the pending slot only when enabled
    btn_req = 4'b0001;
    cyc();
    idle_in();
    cyc();
    btn_req = 4'b0100;
    cyc();
    btn_req = 4'b0010;
    cyc();
    idle_in();
    eng_if.done = 1'b1;
    cyc();
    idle_in();
    auto_en = 1'b1;
    @(negedge clk);
    chk("q_idle", busy, 0);
    chk("q_cnt1", move_count, 3);
`ifdef MOVE_QUEUE_EN
    chk("q_ready", auto_ready, 0);
    cyc();
    auto_en = 1'b0;
    @(negedge clk);
    chk("q_start", eng_if.start, 1);
    chk("q_dir", eng_if.dir, 2);
    cyc();
    eng_if.done = 1'b1;
    cyc();
    idle_in();
    @(negedge clk);
    chk("q_sat", move_count, 3);
`else
    chk("q_ready", auto_ready, 1);
    cyc();
    auto_en = 1'b0;
`endif
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("q_nostart%0d", k), eng_if.start, 0);
      chk($sformatf("q_nobusy%0d", k), busy, 0);
      cyc();
    end

    // Counter saturates at all-ones
    btn_req = 4'b1000;
    cyc();
    idle_in();
    cyc();
    eng_if.done = 1'b1;
    cyc();
    idle_in();
    @(negedge clk);
    chk("sat_cnt", move_count, 3);
    chk("sat_idle", busy, 0);
    cyc();

    // Reset mid-move returns to IDLE with quiet outputs
    btn_req = 4'b0100;
    cyc();
    idle_in();
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_start", eng_if.start, 0);
    chk("mrst_init", eng_if.init, 0);
    chk("mrst_cnt", move_count, 0);
    chk("mrst_tmo", timeout, 0);
    rst = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
